// File: rtl/didactic_bus_pkg.sv
// Shared bus definitions: arbiter state encoding, timeout response word and
// the OBI request/response structs used by the system-bus blocks.
package didactic_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic                    req;
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_rsp_t;

endpackage

// File: rtl/rr_prio_select.sv
// Round-robin priority pick: first asserted request at or after rr_ptr,
// wrapping modulo NUM_MASTERS.
module rr_prio_select #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       rr_ptr,
  output logic [PTR_W-1:0]       winner,
  output logic                   any_req
);

  int unsigned      idx_wide;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    idx_wide = 0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx_wide = (32'(rr_ptr) + i) % NUM_MASTERS;
      idx      = PTR_W'(idx_wide);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/obi_master_arbiter.sv
// Shares one OBI slave port among NUM_MASTERS masters: round-robin, one
// outstanding transaction, response routed to the owner, forced error on timeout.
module obi_master_arbiter
  import didactic_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            m_err,
  output logic                            s_req,
  output logic [ADDR_W-1:0]               s_addr,
  output logic                            s_we,
  output logic [DATA_W/8-1:0]             s_be,
  output logic [DATA_W-1:0]               s_wdata,
  input  logic                            s_gnt,
  input  logic                            s_rvalid,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_err,
  output logic                            timeout_flag
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic [PTR_W-1:0] owner_next;
  logic             timeout_hit;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [BE_W-1:0]   be_arr    [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign be_arr[g]    = m_be[g*BE_W +: BE_W];
    assign wdata_arr[g] = m_wdata[g*DATA_W +: DATA_W];
  end

  rr_prio_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_rr_prio_select (
    .req     (m_req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Request fields are not captured: the owner holds them stable until m_gnt.
  assign s_addr       = addr_arr[owner_q];
  assign s_we         = m_we[owner_q];
  assign s_be         = be_arr[owner_q];
  assign s_wdata      = wdata_arr[owner_q];
  assign timeout_flag = timeout_flag_q;

  assign owner_next  = (32'(owner_q) == NUM_MASTERS - 1) ? '0 : owner_q + 1'b1;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    timeout_flag_d = timeout_flag_q;
    m_gnt          = '0;
    m_rvalid       = '0;
    m_rdata        = '0;
    m_err          = 1'b0;
    s_req          = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A withdrawn request abandons the slot without moving the priority.
        if (!m_req[owner_q]) begin
          state_d = IDLE;
        end else begin
          s_req = 1'b1;
          if (s_gnt) begin
            m_gnt[owner_q] = 1'b1;
            cnt_d          = '0;
            state_d        = RESP;
          end
        end
      end
      RESP: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (s_rvalid) begin
          m_rvalid[owner_q] = 1'b1;
          m_rdata           = s_rdata;
          m_err             = s_err;
          rr_ptr_d          = owner_next;
          state_d           = IDLE;
        end else if (timeout_hit) begin
          m_rvalid[owner_q] = 1'b1;
          m_rdata           = DATA_W'(TIMEOUT_RDATA);
          m_err             = 1'b1;
          timeout_flag_d    = 1'b1;
          rr_ptr_d          = owner_next;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

endmodule

// File: doc/obi_master_arbiter.md
Name: obi_master_arbiter

Overview:
- Shares the single system-bus slave port (interconnect toward instruction memory, L2 and peripherals) between NUM_MASTERS OBI-style masters.
- Master 0 is the debug module system-bus access path used for JTAG program load and status polling. Master 1 is the core data port.
- Round-robin arbitration with one outstanding transaction at a time, response routing back to the owner, and a response timeout so a dead slave cannot hang JTAG polling.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 1024, cycles allowed from slave grant to s_rvalid before an error response is forced (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address
- m_we  in  NUM_MASTERS  per-master write enable
- m_be  in  NUM_MASTERS*DATA_W/8  per-master byte enables
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data
- m_gnt  out  NUM_MASTERS  per-master grant
- m_rvalid  out  NUM_MASTERS  per-master response valid
- m_rdata  out  DATA_W  shared response data, valid with m_rvalid
- m_err  out  1  response error, valid with m_rvalid
- s_req, s_addr, s_we, s_be, s_wdata  out  1/ADDR_W/1/DATA_W/8/DATA_W  slave request
- s_gnt  in  1  slave grant
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_W  slave response data
- s_err  in  1  slave response error
- timeout_flag  out  1  sticky: at least one timeout occurred

Behaviour:
- Reset (reset=0, async): state IDLE, owner=0, rr_ptr=0, counter=0, timeout_flag=0. All m_gnt, m_rvalid, s_req = 0; m_rdata=0, m_err=0.
- IDLE:
  - If any m_req, register winner = first requester at or after rr_ptr (wrapping modulo NUM_MASTERS) into owner; go ADDR.
  - No grant is issued in IDLE.
- ADDR:
  - s_req=1; s_addr/we/be/wdata muxed combinationally from owner.
  - If s_gnt: m_gnt[owner]=1 in the same cycle, clear counter, go RESP.
  - If m_req[owner] drops before grant (protocol violation): s_req deasserts the same cycle, no grant, go IDLE, rr_ptr unchanged.
- RESP:
  - s_req=0; counter increments each cycle.
  - If s_rvalid: m_rvalid[owner]=1, m_rdata=s_rdata, m_err=s_err (combinational pass-through), rr_ptr=owner+1 mod NUM_MASTERS, go IDLE.
  - Else if counter==TIMEOUT-1: m_rvalid[owner]=1, m_rdata=32'hDEAD_BEEF (low DATA_W bits), m_err=1, timeout_flag=1, rr_ptr advanced, go IDLE.
- s_rvalid outside RESP is ignored (stale response after timeout is dropped).
- s_gnt and s_rvalid in the same RESP cycle: only s_rvalid is acted on.
- Latency:
  - Request to m_gnt: minimum 1 cycle (IDLE, then ADDR with s_gnt=1).
  - Transaction cycle: minimum 3 cycles (IDLE, ADDR, RESP with s_rvalid).
- Fairness: a master requesting continuously is served within NUM_MASTERS transactions.
- At most one m_gnt and one m_rvalid bit is high per cycle.
- Owner's request fields are not stored; the master must hold them stable until m_gnt (OBI rule).
- Counter width is $clog2(TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- Shared package didactic_bus_pkg holds:
  - state enum arb_state_e {IDLE, ADDR, RESP};
  - localparam TIMEOUT_RDATA = 32'hDEAD_BEEF;
  - typedefs for the OBI request/response structs, reused by later bus blocks.
- One sub-module: rr_prio_select. Purely combinational; inputs req vector and rr_ptr; outputs winner index and any_req.

Test Plan:
- Single master: m_req[1]=1 read at 0x0100_0080, slave s_gnt=1 immediately, s_rvalid next cycle with 0x1234_5678 -> m_gnt[1] at cycle 1, m_rvalid[1]=1 with m_rdata=0x1234_5678, m_err=0, total 3 cycles.
- Contention: both masters request 4 back-to-back transactions -> grant order 0,1,0,1,… and no master waits more than 1 transaction.
- Timeout: TIMEOUT=16, slave grants but never asserts rvalid -> exactly 16 cycles after grant, m_rvalid=1, m_err=1, m_rdata=0xDEAD_BEEF, timeout_flag=1 and stays 1. A late s_rvalid in IDLE produces no m_rvalid.
- Slave error: s_err=1 with s_rvalid on a write to 0x1A10_40A0 -> m_err=1 routed to owner only.
- Request withdrawal: owner drops m_req in ADDR with s_gnt=0 -> s_req falls the same cycle, no m_gnt, and the next arbitration keeps the same priority.
- Reset mid-transaction: assert reset in RESP -> all outputs 0 immediately (async), state IDLE. After release, a new request completes normally and rr_ptr=0.
